// File: rtl/mips_multicycle_control_unit.sv
// Multi-cycle MIPS control unit: registered FSM sequencing fetch, decode,
// execute, memory and writeback over a unified memory with a MEM_READY wait
// handshake, plus a retired-instruction counter.
// Optional build macro ILLEGAL_OP_TRAP_EN: illegal opcodes park the FSM in a
// TRAP state and raise ILLEGAL_OP until reset; otherwise they retire as NOPs.
module mips_multicycle_control_unit #(
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int STATE_WIDTH    = 4,
  parameter int RET_CNT_WIDTH  = 32
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [5:0]                OP_CODE,
  input  logic [5:0]                FUNCT,
  input  logic                      ZERO_FLAG,
  input  logic                      MEM_READY,
  output logic                      MEM_RD_EN,
  output logic                      MEM_WR_EN,
  output logic                      I_OR_D,
  output logic                      IR_WR_EN,
  output logic                      PC_WR_EN,
  output logic [1:0]                PC_SRC_SEL,
  output logic                      ALU_SRC_A_SEL,
  output logic [1:0]                ALU_SRC_B_SEL,
  output logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL,
  output logic                      REG_FILE_WR_EN,
  output logic                      REG_FILE_A3_SEL,
  output logic                      REG_FILE_WD3_SEL,
  output logic [STATE_WIDTH-1:0]    STATE,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                      ILLEGAL_OP,
`endif
  output logic [RET_CNT_WIDTH-1:0]  RET_CNT
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

  state_t                   state_q, state_d;
  logic [RET_CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
  logic                     retire;

  // Ungated enables; the reset gating below keeps them quiet while RST_N is low.
  logic mem_rd_en, mem_wr_en, ir_wr_en, pc_wr_en, rf_wr_en;
  logic illegal_op;

  // Next-state, retire decision and Moore decode of the datapath controls.
  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    mem_rd_en        = 1'b0;
    mem_wr_en        = 1'b0;
    ir_wr_en         = 1'b0;
    pc_wr_en         = 1'b0;
    rf_wr_en         = 1'b0;
    illegal_op       = 1'b0;
    I_OR_D           = 1'b0;
    PC_SRC_SEL       = 2'b00;
    ALU_SRC_A_SEL    = 1'b0;
    ALU_SRC_B_SEL    = 2'b00;
    ALU_CTRL         = ALU_ADD;
    REG_FILE_A3_SEL  = 1'b0;
    REG_FILE_WD3_SEL = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd_en     = 1'b1;
        ALU_SRC_B_SEL = 2'b01;
        // IR and PC load together on the cycle the memory returns the word.
        ir_wr_en      = MEM_READY;
        pc_wr_en      = MEM_READY;
        if (MEM_READY) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures PC+4 + (imm << 2) for a possible branch.
        ALU_SRC_B_SEL = 2'b11;
        case (OP_CODE)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALU_SRC_A_SEL = 1'b1;
        ALU_SRC_B_SEL = 2'b10;
        state_d       = (OP_CODE == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd_en = 1'b1;
        I_OR_D    = 1'b1;
        if (MEM_READY) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_wr_en         = 1'b1;
        REG_FILE_WD3_SEL = 1'b1;
        retire           = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr_en = 1'b1;
        I_OR_D    = 1'b1;
        if (MEM_READY) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALU_SRC_A_SEL = 1'b1;
        case (FUNCT)
          6'b100010: ALU_CTRL = ALU_SUB;
          6'b100100: ALU_CTRL = ALU_AND;
          6'b100101: ALU_CTRL = ALU_OR;
          6'b101010: ALU_CTRL = ALU_SLT;
          default:   ALU_CTRL = ALU_ADD;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_wr_en        = 1'b1;
        REG_FILE_A3_SEL = 1'b1;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ALU_SRC_A_SEL = 1'b1;
        ALU_CTRL      = ALU_SUB;
        PC_SRC_SEL    = 2'b01;
        pc_wr_en      = ZERO_FLAG;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        ALU_SRC_A_SEL = 1'b1;
        ALU_SRC_B_SEL = 2'b10;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_wr_en = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PC_SRC_SEL = 2'b10;
        pc_wr_en   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
        // Parked until reset; counter frozen, no enables.
        illegal_op = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    ret_cnt_d = retire ? ret_cnt_q + RET_CNT_WIDTH'(1) : ret_cnt_q;
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_FETCH;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign MEM_RD_EN      = mem_rd_en & RST_N;
  assign MEM_WR_EN      = mem_wr_en & RST_N;
  assign IR_WR_EN       = ir_wr_en & RST_N;
  assign PC_WR_EN       = pc_wr_en & RST_N;
  assign REG_FILE_WR_EN = rf_wr_en & RST_N;
  assign STATE          = STATE_WIDTH'(state_q);
  assign RET_CNT        = ret_cnt_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign ILLEGAL_OP     = illegal_op;
`endif

endmodule

// File: tb/tb_mips_multicycle_control_unit.sv
// Scoreboard bench for mips_multicycle_control_unit: the driver expands each
// instruction into its expected per-cycle state/control record and queues it;
// a monitor pops and compares one record per cycle on the falling edge.
module tb_mips_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [5:0]  OP_CODE = 6'd0;
  logic [5:0]  FUNCT = 6'd0;
  logic        ZERO_FLAG = 1'b0;
  logic        MEM_READY = 1'b0;
  logic        MEM_RD_EN, MEM_WR_EN, I_OR_D, IR_WR_EN, PC_WR_EN;
  logic [1:0]  PC_SRC_SEL;
  logic        ALU_SRC_A_SEL;
  logic [1:0]  ALU_SRC_B_SEL;
  logic [2:0]  ALU_CTRL;
  logic        REG_FILE_WR_EN, REG_FILE_A3_SEL, REG_FILE_WD3_SEL;
  logic [3:0]  STATE;
  logic [31:0] RET_CNT;
  logic        ill_w;

  mips_multicycle_control_unit dut (
    .CLK(CLK), .RST_N(RST_N), .OP_CODE(OP_CODE), .FUNCT(FUNCT),
    .ZERO_FLAG(ZERO_FLAG), .MEM_READY(MEM_READY),
    .MEM_RD_EN(MEM_RD_EN), .MEM_WR_EN(MEM_WR_EN), .I_OR_D(I_OR_D),
    .IR_WR_EN(IR_WR_EN), .PC_WR_EN(PC_WR_EN), .PC_SRC_SEL(PC_SRC_SEL),
    .ALU_SRC_A_SEL(ALU_SRC_A_SEL), .ALU_SRC_B_SEL(ALU_SRC_B_SEL),
    .ALU_CTRL(ALU_CTRL), .REG_FILE_WR_EN(REG_FILE_WR_EN),
    .REG_FILE_A3_SEL(REG_FILE_A3_SEL), .REG_FILE_WD3_SEL(REG_FILE_WD3_SEL),
    .STATE(STATE),
`ifdef ILLEGAL_OP_TRAP_EN
    .ILLEGAL_OP(ill_w),
`endif
    .RET_CNT(RET_CNT)
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign ill_w = 1'b0;
`endif

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  st;
    logic        rd, wr, iord, irwr, pcwr;
    logic [1:0]  pcsrc;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  alu;
    logic        rfwr, a3, wd3, ill;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ret = 0;

  // Named phases of an instruction (state numbers as exposed on STATE).
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                 P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7,
                 P_BRANCH = 8, P_ADDIEX = 9, P_ADDIWB = 10, P_JUMP = 11,
                 P_TRAP = 12;

  // What the control outputs must look like in a given phase.
  function automatic exp_t exp_for(input int ph, input logic rdy,
                                   input logic z, input logic [5:0] fn);
    exp_t e;
    e = '0;
    e.st  = 4'(ph);
    e.alu = 3'b010;
    e.ret = model_ret;
    case (ph)
      P_FETCH:  begin e.rd = 1; e.srcb = 2'b01; e.irwr = rdy; e.pcwr = rdy; end
      P_DECODE: e.srcb = 2'b11;
      P_MEMADR: begin e.srca = 1; e.srcb = 2'b10; end
      P_MEMRD:  begin e.rd = 1; e.iord = 1; end
      P_MEMWB:  begin e.rfwr = 1; e.wd3 = 1; end
      P_MEMWR:  begin e.wr = 1; e.iord = 1; end
      P_EXEC: begin
        e.srca = 1;
        if (fn == 6'b100010) e.alu = 3'b110;
        else if (fn == 6'b100100) e.alu = 3'b000;
        else if (fn == 6'b100101) e.alu = 3'b001;
        else if (fn == 6'b101010) e.alu = 3'b111;
      end
      P_ALUWB:  begin e.rfwr = 1; e.a3 = 1; end
      P_BRANCH: begin e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcwr = z; end
      P_ADDIEX: begin e.srca = 1; e.srcb = 2'b10; end
      P_ADDIWB: e.rfwr = 1;
      P_JUMP:   begin e.pcsrc = 2'b10; e.pcwr = 1; end
      P_TRAP:   e.ill = 1;
      default:  ;
    endcase
    return e;
  endfunction

  // Monitor: one comparison per cycle that has a queued expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {STATE, MEM_RD_EN, MEM_WR_EN, I_OR_D, IR_WR_EN, PC_WR_EN,
             PC_SRC_SEL, ALU_SRC_A_SEL, ALU_SRC_B_SEL, ALU_CTRL,
             REG_FILE_WR_EN, REG_FILE_A3_SEL, REG_FILE_WD3_SEL, ill_w, RET_CNT};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t state: got %h expected %h (st=%0d ret=%0d vs st=%0d ret=%0d)",
                   $time, a, e, a.st, a.ret, e.st, e.ret);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Enter at posedge+1; asserts reset after the pending monitor compare,
  // checks asynchronous clearing, then releases with the FSM idle in FETCH.
  task automatic do_reset(input int pre_state);
    @(negedge CLK); #1;
    if (pre_state >= 0) chk("pre_reset_state", 32'(STATE), 32'(pre_state));
    MEM_READY = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_state", 32'(STATE), 0);
    chk("rst_ret_cnt", RET_CNT, 0);
    chk("rst_enables", {27'd0, MEM_RD_EN, MEM_WR_EN, IR_WR_EN, PC_WR_EN, REG_FILE_WR_EN}, 0);
    chk("rst_illegal_op", 32'(ill_w), 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hold_enables", {27'd0, MEM_RD_EN, MEM_WR_EN, IR_WR_EN, PC_WR_EN, REG_FILE_WR_EN}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_ret = 0;
    @(posedge CLK); #1;
  endtask

  // Expand one instruction into its phase list and queue expectations.
  // zsel < 0 means random ZERO_FLAG. abort stops sw in a stalled MEMWR.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input int zsel, input bit abort);
    int   ph[$];
    bit   rd[$];
    bit   retires;
    retires = 1'b1;
    for (int i = 0; i < wf; i++) begin ph.push_back(P_FETCH); rd.push_back(1'b0); end
    ph.push_back(P_FETCH);  rd.push_back(1'b1);
    ph.push_back(P_DECODE); rd.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin ph.push_back(P_MEMRD); rd.push_back(1'b0); end
        ph.push_back(P_MEMRD); rd.push_back(1'b1);
        ph.push_back(P_MEMWB); rd.push_back(1'($urandom));
      end
      6'b101011: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin ph.push_back(P_MEMWR); rd.push_back(1'b0); end
        if (abort) retires = 1'b0;
        else begin ph.push_back(P_MEMWR); rd.push_back(1'b1); end
      end
      6'b000000: begin
        ph.push_back(P_EXEC);  rd.push_back(1'($urandom));
        ph.push_back(P_ALUWB); rd.push_back(1'($urandom));
      end
      6'b000100: begin ph.push_back(P_BRANCH); rd.push_back(1'($urandom)); end
      6'b001000: begin
        ph.push_back(P_ADDIEX); rd.push_back(1'($urandom));
        ph.push_back(P_ADDIWB); rd.push_back(1'($urandom));
      end
      6'b000010: begin ph.push_back(P_JUMP); rd.push_back(1'($urandom)); end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        retires = 1'b0;
        for (int i = 0; i < 10; i++) begin ph.push_back(P_TRAP); rd.push_back(1'($urandom)); end
`endif
      end
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      OP_CODE   = op;
      FUNCT     = fn;
      MEM_READY = rd[i];
      ZERO_FLAG = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      sb.push_back(exp_for(ph[i], MEM_READY, ZERO_FLAG, FUNCT));
      @(posedge CLK); #1;
    end
    if (retires) model_ret++;
    $display("instr op=%b funct=%b waits=%0d/%0d cycles=%0d retired=%0d ret_cnt_exp=%0d",
             op, fn, wf, wm, ph.size(), retires, model_ret);
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};

    @(posedge CLK); #1;
    do_reset(-1);

    // Directed sequences from the test plan.
    run_instr(6'b100011, 6'd0, 2, 2, -1, 1'b0);     // lw with stalls
    run_instr(6'b000000, 6'b101010, 0, 0, -1, 1'b0); // slt
    run_instr(6'b000100, 6'd0, 0, 0, 1, 1'b0);      // beq taken
    run_instr(6'b000100, 6'd0, 0, 0, 0, 1'b0);      // beq not taken
    run_instr(6'b000010, 6'd0, 0, 0, -1, 1'b0);     // j
    run_instr(6'b101011, 6'd0, 0, 0, -1, 1'b0);     // sw
`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(6'b111111, 6'd0, 0, 0, -1, 1'b0);     // trap for 10 cycles
    do_reset(12);
`else
    run_instr(6'b111111, 6'd0, 0, 0, -1, 1'b0);     // illegal retires as NOP
`endif
    run_instr(6'b001000, 6'd0, 1, 0, -1, 1'b0);     // addi
    run_instr(6'b101011, 6'd0, 1, 2, -1, 1'b1);     // sw aborted in MEMWR
    do_reset(5);

    // Randomized instruction mix.
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
`ifdef ILLEGAL_OP_TRAP_EN
      if (op == 6'b111111) op = 6'b000000;
`else
      if (op == 6'b111111) op = 6'($urandom_range(48, 63));
`endif
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b0);
    end

    @(negedge CLK); #1;
    chk("final_ret_cnt", RET_CNT, model_ret);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
